// File: rtl/mul32_seq_if.sv
// rtl/mul32_seq_if.sv - start/done handshake bundle for the sequential multiplier
//
// Signals:
//   start   : request from the control unit, sampled by the multiplier only when idle
//   a, b    : multiplicand / multiplier, captured on the accepted start edge
//   busy    : multiply in flight (RUN or DONE)
//   done    : one-cycle completion pulse
//   product : 2*WIDTH-bit result, held until the next accepted start or reset
// Modports: master drives the request side, slave is the multiplier.
interface mul32_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mul32_seq.sv
// rtl/mul32_seq.sv - sequential shift-and-add unsigned multiplier, one add per clock
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : mul32_seq_if.slave (start, a, b in; busy, done, product out)
// A multiply takes WIDTH RUN cycles followed by a single DONE cycle.
module mul32_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mul32_seq_if.slave    bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     acc_hi;
    logic [WIDTH-1:0]     acc_lo;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     acc_hi_nxt;
    logic [WIDTH-1:0]     acc_lo_nxt;
    logic                 last_iter;

    // One partial product per cycle. The carry-out lands in the top bit of
    // acc_hi after the right shift, so nothing is ever lost.
    always_comb begin
        addend     = acc_lo[0] ? mcand : {WIDTH{1'b0}};
        sum        = {1'b0, acc_hi} + {1'b0, addend};
        acc_hi_nxt = sum[WIDTH:1];
        acc_lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
        last_iter  = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= bus.a;
                        acc_hi <= '0;
                        acc_lo <= bus.b;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc_hi <= acc_hi_nxt;
                    acc_lo <= acc_lo_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        product_q <= {acc_hi_nxt, acc_lo_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs come only from registers or state decode; start/a/b never
    // reach them combinationally.
    assign bus.busy    = (state == RUN) || (state == DONE);
    assign bus.done    = (state == DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_mul32_seq.sv
// tb/tb_mul32_seq.sv - directed self-checking bench for mul32_seq
module tb_mul32_seq;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   assertions;
    int   failures;

    mul32_seq_if #(.WIDTH(WIDTH)) bus ();

    mul32_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start and wait (bounded) for done; returns edges from accept to done.
    task automatic run_mul(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           output int cycles, output logic [2*WIDTH-1:0] prod,
                           output logic busy_after_accept);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        tick();
        bus.start = 1'b0;
        bus.a     = '1;
        bus.b     = '1;
        busy_after_accept = bus.busy;
        cycles = 0;
        while (!bus.done && cycles < 100) begin
            tick();
            cycles++;
        end
        prod = bus.product;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        tick();
        tick();
        bus.start = 1'b0;
        rst_n     = 1'b1;
        tick();
        assertions++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %0b expected 0", bus.busy);
        end
        assertions++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %0b expected 0", bus.done);
        end
        assertions++;
        if (bus.product !== 64'h0) begin
            failures++;
            $display("FAIL reset_product: got %h expected 0", bus.product);
        end
    endtask

    task automatic test_basic();
        int cyc;
        logic [2*WIDTH-1:0] p;
        logic bz;
        run_mul(32'd3, 32'd5, cyc, p, bz);
        assertions++;
        if (bz !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_after_accept: got %0b expected 1", bz);
        end
        assertions++;
        if (cyc !== 32) begin
            failures++;
            $display("FAIL basic_latency: got %0d expected 32", cyc);
        end
        assertions++;
        if (p !== 64'h000000000000000F) begin
            failures++;
            $display("FAIL basic_product: got %h expected 000000000000000f", p);
        end
        tick();
        assertions++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_return_idle: done=%0b busy=%0b expected 0 0", bus.done, bus.busy);
        end
        tick();
        assertions++;
        if (bus.product !== 64'h000000000000000F) begin
            failures++;
            $display("FAIL basic_product_held: got %h expected 000000000000000f", bus.product);
        end
    endtask

    task automatic test_carries();
        int cyc;
        logic [2*WIDTH-1:0] p;
        logic bz;
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, cyc, p, bz);
        tick();
        assertions++;
        if (p !== 64'hFFFFFFFE00000001) begin
            failures++;
            $display("FAIL carries_all_ones: got %h expected fffffffe00000001", p);
        end
        run_mul(32'h80000000, 32'd2, cyc, p, bz);
        tick();
        assertions++;
        if (p !== 64'h0000000100000000) begin
            failures++;
            $display("FAIL carries_msb_times_2: got %h expected 0000000100000000", p);
        end
    endtask

    task automatic test_zero();
        int cyc;
        logic [2*WIDTH-1:0] p;
        logic bz;
        run_mul(32'd0, 32'h12345678, cyc, p, bz);
        tick();
        assertions++;
        if (cyc !== 32) begin
            failures++;
            $display("FAIL zero_latency: got %0d expected 32", cyc);
        end
        assertions++;
        if (p !== 64'h0) begin
            failures++;
            $display("FAIL zero_product: got %h expected 0", p);
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        int cyc;
        logic [2*WIDTH-1:0] p;
        logic bz;
        dones = 0;
        p     = '0;
        bus.start = 1'b1;
        bus.a     = 32'd7;
        bus.b     = 32'd9;
        tick();
        // Edges E+5 and E+32 are in RUN, E+33 is in DONE.
        for (int k = 1; k <= 40; k++) begin
            bus.start = (k == 5 || k == 32 || k == 33);
            bus.a     = 32'd1;
            bus.b     = 32'd1;
            tick();
            if (bus.done) begin
                dones++;
                p = bus.product;
            end
        end
        bus.start = 1'b0;
        assertions++;
        if (p !== 64'd63) begin
            failures++;
            $display("FAIL ignore_start_product: got %0d expected 63", p);
        end
        assertions++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL ignore_start_done_count: got %0d expected 1", dones);
        end
        assertions++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start_idle: busy got %0b expected 0", bus.busy);
        end
        run_mul(32'd1, 32'd1, cyc, p, bz);
        tick();
        assertions++;
        if (p !== 64'd1) begin
            failures++;
            $display("FAIL ignore_start_second: got %0d expected 1", p);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        int cyc;
        logic [2*WIDTH-1:0] p;
        logic bz;
        dones = 0;
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd200;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        assertions++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'h0) begin
            failures++;
            $display("FAIL midrun_reset_state: busy=%0b done=%0b product=%h expected 0 0 0",
                     bus.busy, bus.done, bus.product);
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.done) dones++;
        end
        assertions++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL midrun_no_done: got %0d done pulses expected 0", dones);
        end
        run_mul(32'd6, 32'd7, cyc, p, bz);
        tick();
        assertions++;
        if (p !== 64'd42) begin
            failures++;
            $display("FAIL midrun_restart: got %0d expected 42", p);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int pulses;
        int last_pulse;
        int bad_gap;
        int unstable;
        cyc        = 0;
        pulses     = 0;
        last_pulse = 0;
        bad_gap    = 0;
        unstable   = 0;
        bus.start  = 1'b1;
        bus.a      = 32'h10000;
        bus.b      = 32'h10000;
        while (pulses < 3 && cyc < 150) begin
            tick();
            cyc++;
            if (pulses > 0 && bus.product !== 64'h0000000100000000) unstable++;
            if (bus.done) begin
                if (pulses > 0 && (cyc - last_pulse) != 34) bad_gap++;
                if (pulses == 0 && bus.product !== 64'h0000000100000000) unstable++;
                pulses++;
                last_pulse = cyc;
            end
        end
        bus.start = 1'b0;
        assertions++;
        if (pulses !== 3) begin
            failures++;
            $display("FAIL b2b_pulse_count: got %0d expected 3 within budget", pulses);
        end
        assertions++;
        if (bad_gap !== 0) begin
            failures++;
            $display("FAIL b2b_period: %0d gaps differ from 34 expected 0", bad_gap);
        end
        assertions++;
        if (unstable !== 0) begin
            failures++;
            $display("FAIL b2b_product: %0d cycles without 0000000100000000 expected 0", unstable);
        end
        for (int k = 0; k < 40; k++) tick();
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        test_reset();
        test_basic();
        test_carries();
        test_zero();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
